// File: rtl/mouse_axis_emu.sv
// Mouse-to-analog-axis emulator: integrates PS/2 relative motion into saturating
// signed X/Y axes and muxes them (plus mouse buttons) over the native joystick.
module mouse_axis_emu #(
   parameter int unsigned AXIS_W      = 8,
   parameter int unsigned DELTA_SHIFT = 1,
   parameter int unsigned STEP_MAX    = 10,
   parameter int unsigned CENTER_DIV  = 65536,
   parameter int unsigned IDLE_CYCLES = 0
) (
   input  logic              clk_sys_i,
   input  logic              reset_i,
   input  logic [24:0]       ps2_mouse_i,
   input  logic [15:0]       joya_i,
   input  logic [1:0]        joy_btn_i,
   input  logic              release_i,
   input  logic [1:0]        mode_i,
   output logic              emu_active_o,
   output logic [AXIS_W-1:0] axis_x_o,
   output logic [AXIS_W-1:0] axis_y_o,
   output logic [1:0]        btn_out_o
);

   localparam int unsigned SUM_W  = AXIS_W + 1;
   localparam int unsigned PRE_W  = $clog2(CENTER_DIV);
   localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

   localparam logic signed [SUM_W-1:0] STEP_P    = SUM_W'(STEP_MAX);
   localparam logic signed [SUM_W-1:0] STEP_N    = -STEP_P;
   localparam logic signed [SUM_W-1:0] ACC_MAX   = SUM_W'((1 << (AXIS_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] ACC_MIN   = ~ACC_MAX;
   localparam logic [PRE_W-1:0]        PRE_LAST  = PRE_W'(CENTER_DIV - 1);
   localparam logic [IDLE_W-1:0]       IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

   logic                     old_stb_q, old_stb_d;
   logic                     active_q, active_d;
   logic signed [AXIS_W-1:0] acc_x_q, acc_x_d;
   logic signed [AXIS_W-1:0] acc_y_q, acc_y_d;
   logic [PRE_W-1:0]         presc_q, presc_d;
   logic [IDLE_W-1:0]        idle_q, idle_d;

   logic                     pkt, rel, tick, idle_hit;
   logic signed [SUM_W-1:0]  dx, dy;
   logic [AXIS_W+7:0]        pass_x, pass_y;
   logic                     unused_bits;

   // Sign-extend the 9-bit raw delta, scale it down, clamp to the step limit.
   function automatic logic signed [SUM_W-1:0] scale_delta(input logic sgn, input logic [7:0] mag);
      logic signed [SUM_W-1:0] d;
      d = SUM_W'($signed({sgn, mag}));
      d = d >>> DELTA_SHIFT;
      if (d > STEP_P)      d = STEP_P;
      else if (d < STEP_N) d = STEP_N;
      return d;
   endfunction

   function automatic logic signed [AXIS_W-1:0] sat_add(input logic signed [AXIS_W-1:0] acc,
                                                        input logic signed [SUM_W-1:0]  d);
      logic signed [SUM_W-1:0] s;
      s = SUM_W'(acc) + d;
      if (s > ACC_MAX)      s = ACC_MAX;
      else if (s < ACC_MIN) s = ACC_MIN;
      return AXIS_W'(s);
   endfunction

   function automatic logic signed [AXIS_W-1:0] decay(input logic signed [AXIS_W-1:0] a);
      if (a == '0) return a;
      return a[AXIS_W-1] ? a + AXIS_W'(1) : a - AXIS_W'(1);
   endfunction

   // Release beats packet, packet beats idle timeout, timeout beats auto-centre.
   always_comb begin
      old_stb_d = ps2_mouse_i[24];
      active_d  = active_q;
      acc_x_d   = acc_x_q;
      acc_y_d   = acc_y_q;
      idle_d    = idle_q;
      pkt       = ps2_mouse_i[24] ^ old_stb_q;
      rel       = (joya_i != 16'd0) | release_i;
      tick      = (presc_q == PRE_LAST);
      idle_hit  = (IDLE_CYCLES != 0) && (idle_q == IDLE_LAST);
      presc_d   = tick ? '0 : presc_q + PRE_W'(1);
      dx        = scale_delta(ps2_mouse_i[4], ps2_mouse_i[15:8]);
      dy        = scale_delta(ps2_mouse_i[5], ps2_mouse_i[23:16]);
      if (mode_i[1]) dy = -dy;

      if (rel) begin
         active_d = 1'b0;
         acc_x_d  = '0;
         acc_y_d  = '0;
         idle_d   = '0;
      end else if (pkt) begin
         active_d = 1'b1;
         acc_x_d  = sat_add(acc_x_q, dx);
         acc_y_d  = sat_add(acc_y_q, dy);
         idle_d   = '0;
      end else if (active_q) begin
         if (idle_hit) begin
            active_d = 1'b0;
            acc_x_d  = '0;
            acc_y_d  = '0;
            idle_d   = '0;
         end else begin
            if (IDLE_CYCLES != 0) idle_d = idle_q + IDLE_W'(1);
            if (tick && mode_i[0]) begin
               acc_x_d = decay(acc_x_q);
               acc_y_d = decay(acc_y_q);
            end
         end
      end
   end

   always_ff @(posedge clk_sys_i or posedge reset_i) begin
      if (reset_i) begin
         old_stb_q <= 1'b0;
         active_q  <= 1'b0;
         acc_x_q   <= '0;
         acc_y_q   <= '0;
         presc_q   <= '0;
         idle_q    <= '0;
      end else begin
         old_stb_q <= old_stb_d;
         active_q  <= active_d;
         acc_x_q   <= acc_x_d;
         acc_y_q   <= acc_y_d;
         presc_q   <= presc_d;
         idle_q    <= idle_d;
      end
   end

   // Native joystick bytes are left-aligned into the wider axis.
   assign pass_x      = {joya_i[7:0], AXIS_W'(0)};
   assign pass_y      = {joya_i[15:8], AXIS_W'(0)};
   assign emu_active_o = active_q;
   assign axis_x_o    = active_q ? acc_x_q : pass_x[AXIS_W+7 -: AXIS_W];
   assign axis_y_o    = active_q ? acc_y_q : pass_y[AXIS_W+7 -: AXIS_W];
   assign btn_out_o   = active_q ? ps2_mouse_i[1:0] : joy_btn_i;
   assign unused_bits = ^{ps2_mouse_i[7:6], ps2_mouse_i[3:2]};

endmodule

// File: doc/mouse_axis_emu.md
Name: mouse_axis_emu

Overview:
- Parametrised PS/2-mouse-to-analog-axis emulator for port 1 paddle/analog inputs.
- Accumulates relative mouse motion into saturating signed X/Y axes.
- Muxes the accumulated axes and the mouse buttons over the native analog joystick and fire buttons.
- Adds configurable step scaling and clamping, Y inversion, optional auto-centre decay and an idle timeout that releases emulation.
- Sits between hps_io (ps2_mouse, joystick_analog) and the machine core's JOYnX/JOYnY/JOYn inputs.

Parameters:
AXIS_W, 8, axis width in bits, signed two's complement; legal range 8..12.
DELTA_SHIFT, 1, arithmetic right shift applied to each raw mouse delta.
STEP_MAX, 10, per-packet clamp magnitude after the shift; must be below 2^(AXIS_W-1).
CENTER_DIV, 65536, clock cycles between auto-centre decay ticks; minimum 2.
IDLE_CYCLES, 0, cycles without a packet before emulation releases; 0 disables the timeout.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_mouse  in  25  hps_io mouse packet: [24] toggle strobe, [23:16] dy, [15:8] dx, [5] y sign, [4] x sign, [1:0] buttons
joya  in  16  native analog joystick, [7:0] X, [15:8] Y, signed
joy_btn  in  2  native fire buttons
release  in  1  forces emulation off while high (e.g. CPU halt)
mode  in  2  [0] auto-centre enable, [1] invert Y
emu_active  out  1  1 = mouse drives the axes
axis_x  out  AXIS_W  X axis to the core
axis_y  out  AXIS_W  Y axis to the core
btn_out  out  2  buttons to the core

Behaviour:
- Reset values (asynchronous): emu_active=0, acc_x=acc_y=0, old_stb=0, idle counter 0, prescaler 0.
- Packet detect: pkt = (ps2_mouse[24] != old_stb); old_stb <= ps2_mouse[24] every cycle.
  - A strobe already at 1 when reset releases counts as one packet.
- Delta path for X (combinational, 1 cycle to register):
  - raw = {sign, data[7:0]}, a 9-bit signed value.
  - d = raw >>> DELTA_SHIFT (arithmetic shift).
  - Clamp d to [-STEP_MAX, +STEP_MAX].
- Delta path for Y: same as X; when mode[1]=1, negate after the clamp.
- Accumulate on pkt:
  - Compute acc + d at AXIS_W+1 bits.
  - Saturate to [-2^(AXIS_W-1), 2^(AXIS_W-1)-1].
  - Register the result; emu_active <= 1.
  - The new axis value is visible on the clock edge after the cycle in which pkt=1.
- Release condition: (joya != 0) | release.
  - Acts on the next edge: emu_active <= 0, acc_x = acc_y = 0, idle counter cleared.
  - Has priority over a pkt in the same cycle; that packet is discarded.
- Idle timeout (IDLE_CYCLES > 0 only):
  - Counter increments each cycle while emu_active=1 and pkt=0.
  - Counter clears on pkt.
  - When the counter = IDLE_CYCLES-1: emu_active <= 0, accumulators zeroed, counter 0.
  - A pkt in that same cycle wins: counter clears and the accumulate proceeds.
- Auto-centre (mode[0]=1):
  - Free-running prescaler over 0..CENTER_DIV-1; tick when it equals CENTER_DIV-1.
  - On a tick with pkt=0 and emulation active, each nonzero accumulator moves 1 toward 0; zero stays zero.
  - A tick coincident with pkt is skipped, not deferred.
  - With mode[0]=0 the accumulators hold their value.
  - Changing mode mid-operation takes effect on the next cycle; no other state changes.
- Output mux (combinational):
  - axis_x = emu_active ? acc_x : {joya[7:0], (AXIS_W-8) zeros}; axis_y likewise from joya[15:8].
  - btn_out = emu_active ? ps2_mouse[1:0] : joy_btn.
- Reset asserted mid-operation clears all state immediately, independent of the clock.

Test Plan:
1. Reset, then toggle strobe with dx=+20 (x sign 0) and defaults -> d=10 after the shift, clamped 10; axis_x=10 one cycle later; emu_active=1; btn_out follows ps2_mouse[1:0].
2. 20 packets with dx=+20 -> axis_x saturates at 127; next packet with dx=-4 -> axis_x=125.
3. mode[1]=1 and packet with dy=+6 -> axis_y=-3. Then joya=16'h0100 asserted in the same cycle as a packet -> emu_active=0, axis_y=1<<(AXIS_W-8) passthrough, packet ignored.
4. CENTER_DIV=4, mode[0]=1, acc_x=5 -> axis_x steps 4,3,2,1,0 at 4-cycle intervals, then holds 0.
5. IDLE_CYCLES=100, single packet -> emu_active drops exactly 100 cycles after the accumulate edge; a packet at cycle 99 keeps it at 1.
6. AXIS_W=10, release pulsed high for 1 cycle -> axes=0, emu_active=0. Then a packet with dx=-255 -> d=-10 (clamped from -128); axis_x=-10.
